// File: rtl/branch_predict_flush_unit.sv
// Control-hazard unit: counter-table branch predictor plus flush / PC-select generation.
// Latency: lookup, flush and pcsel are combinational (same cycle); table and stat update on the clock edge.
// Backpressure: stall freezes the table update and stat counter only; flush/pcsel still assert under stall.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   id_branch, id_jump   conditional branch / unconditional jump valid in ID
//   id_pc                PC of the ID instruction (table lookup)
//   ex_branch, ex_pc     conditional branch resolving in EX and its PC (table update)
//   ex_taken             resolved outcome of the EX branch
//   ex_predicted         prediction that travelled down the pipe with the EX branch
//   stall                pipeline stall
//   predict_taken        prediction for the ID branch
//   ifidflush, idexflush, exmemflush   per-register flush strobes
//   pcsel                00 PC+4, 01 ID target, 10 EX target, 11 ex_pc+4
//   mispredict_count     saturating misprediction counter
module branch_predict_flush_unit #(
  parameter int PC_WIDTH   = 32,
  parameter int INDEX_BITS = 4,
  parameter int CNT_BITS   = 2,
  parameter int DYNAMIC    = 1,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_branch,
  input  logic                  id_jump,
  input  logic [PC_WIDTH-1:0]   id_pc,
  input  logic                  ex_branch,
  input  logic [PC_WIDTH-1:0]   ex_pc,
  input  logic                  ex_taken,
  input  logic                  ex_predicted,
  input  logic                  stall,
  output logic                  predict_taken,
  output logic                  ifidflush,
  output logic                  idexflush,
  output logic                  exmemflush,
  output logic [1:0]            pcsel,
  output logic [STAT_WIDTH-1:0] mispredict_count
);

  localparam int                  ENTRIES  = 1 << INDEX_BITS;
  localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
  // Weakly-not-taken: just below the MSB threshold.
  localparam logic [CNT_BITS-1:0] CNT_WNT  = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
  localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;
  localparam logic                DYN_EN   = (DYNAMIC != 0);

  localparam logic [1:0] PCSEL_SEQ    = 2'b00;
  localparam logic [1:0] PCSEL_ID     = 2'b01;
  localparam logic [1:0] PCSEL_EX_TGT = 2'b10;
  localparam logic [1:0] PCSEL_EX_SEQ = 2'b11;

  logic [CNT_BITS-1:0]   ctr_tbl [ENTRIES];
  logic [INDEX_BITS-1:0] id_idx;
  logic [INDEX_BITS-1:0] ex_idx;
  logic [CNT_BITS-1:0]   ex_ctr;
  logic [CNT_BITS-1:0]   ex_ctr_next;
  logic                  mispredict;

  // Only the word-index bits of the PCs select a counter; the rest are ignored
  // (aliasing PCs share an entry, there is no tag).
  logic unused_pc_bits;
  assign unused_pc_bits = ^{id_pc, ex_pc};

  assign id_idx = id_pc[INDEX_BITS+1:2];
  assign ex_idx = ex_pc[INDEX_BITS+1:2];
  assign ex_ctr = ctr_tbl[ex_idx];

  // Lookup reads the registered table, so a same-cycle update to the same
  // entry is not visible until the following cycle.
  assign predict_taken = id_branch & DYN_EN & ctr_tbl[id_idx][CNT_BITS-1];

  assign mispredict = ex_branch & (ex_taken ^ ex_predicted);

  // Saturating step of the counter being trained.
  always_comb begin
    ex_ctr_next = ex_ctr;
    if (ex_taken) begin
      if (ex_ctr != CNT_MAX) ex_ctr_next = ex_ctr + CNT_BITS'(1);
    end else begin
      if (ex_ctr != '0) ex_ctr_next = ex_ctr - CNT_BITS'(1);
    end
  end

  // Fixed-priority event resolution: an EX mispredict squashes everything
  // younger, so any ID redirect in the same cycle is wrong-path and ignored.
  always_comb begin
    ifidflush  = 1'b0;
    idexflush  = 1'b0;
    exmemflush = 1'b0;
    pcsel      = PCSEL_SEQ;
    if (!reset) begin
      if (mispredict) begin
        ifidflush  = 1'b1;
        idexflush  = 1'b1;
        exmemflush = 1'b1;
        pcsel      = ex_taken ? PCSEL_EX_TGT : PCSEL_EX_SEQ;
      end else if (id_jump || predict_taken) begin
        ifidflush  = 1'b1;
        pcsel      = PCSEL_ID;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_tbl[i] <= CNT_WNT;
      end
      mispredict_count <= '0;
    end else begin
      // The table trains even when DYNAMIC is 0 so it is warm if re-enabled.
      if (ex_branch && !stall) begin
        ctr_tbl[ex_idx] <= ex_ctr_next;
      end
      if (mispredict && !stall && (mispredict_count != STAT_MAX)) begin
        mispredict_count <= mispredict_count + STAT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_predict_flush_unit.sv
module tb_branch_predict_flush_unit;

  typedef struct {
    logic        pt;
    logic [2:0]  fl;
    logic [1:0]  pcsel;
    logic [15:0] cnt;
    logic        pt0;
    logic [2:0]  fl0;
    logic [1:0]  pcsel0;
    logic [1:0]  cnt0;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        id_branch;
  logic        id_jump;
  logic [31:0] id_pc;
  logic        ex_branch;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic        ex_predicted;
  logic        stall;

  logic        predict_taken, ifidflush, idexflush, exmemflush;
  logic [1:0]  pcsel;
  logic [15:0] mispredict_count;

  logic        predict_taken0, ifidflush0, idexflush0, exmemflush0;
  logic [1:0]  pcsel0;
  logic [1:0]  mispredict_count0;

  int checks   = 0;
  int failures = 0;

  // Reference state
  logic [1:0]  ref_tbl [16];
  logic [15:0] ref_stat;
  logic [1:0]  ref_stat0;
  exp_t        exp_q [$];

  branch_predict_flush_unit #(
    .PC_WIDTH(32), .INDEX_BITS(4), .CNT_BITS(2), .DYNAMIC(1), .STAT_WIDTH(16)
  ) u_dut (
    .clk(clk), .reset(reset),
    .id_branch(id_branch), .id_jump(id_jump), .id_pc(id_pc),
    .ex_branch(ex_branch), .ex_pc(ex_pc), .ex_taken(ex_taken),
    .ex_predicted(ex_predicted), .stall(stall),
    .predict_taken(predict_taken), .ifidflush(ifidflush), .idexflush(idexflush),
    .exmemflush(exmemflush), .pcsel(pcsel), .mispredict_count(mispredict_count)
  );

  // Legacy configuration: never predicts taken, so ex_predicted is always 0.
  // Small stat width exercises counter saturation.
  branch_predict_flush_unit #(
    .PC_WIDTH(32), .INDEX_BITS(4), .CNT_BITS(2), .DYNAMIC(0), .STAT_WIDTH(2)
  ) u_dut0 (
    .clk(clk), .reset(reset),
    .id_branch(id_branch), .id_jump(id_jump), .id_pc(id_pc),
    .ex_branch(ex_branch), .ex_pc(ex_pc), .ex_taken(ex_taken),
    .ex_predicted(1'b0), .stall(stall),
    .predict_taken(predict_taken0), .ifidflush(ifidflush0), .idexflush(idexflush0),
    .exmemflush(exmemflush0), .pcsel(pcsel0), .mispredict_count(mispredict_count0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) ref_tbl[i] = 2'b01;
    ref_stat  = '0;
    ref_stat0 = '0;
  endtask

  // Priority resolution as stated: mispredict > jump > predicted-taken > none.
  task automatic resolve(input logic rs, input logic misp, input logic et,
                         input logic ij, input logic pt,
                         output logic [2:0] fl, output logic [1:0] ps);
    fl = 3'b000;
    ps = 2'b00;
    if (!rs) begin
      if (misp) begin
        fl = 3'b111;
        ps = et ? 2'b10 : 2'b11;
      end else if (ij || pt) begin
        fl = 3'b100;
        ps = 2'b01;
      end
    end
  endtask

  // One cycle: drive at posedge+1, check at negedge, advance the model at posedge.
  task automatic step(input string tag, input logic rs, input logic ib, input logic ij,
                      input logic [31:0] ipc, input logic eb, input logic [31:0] epc,
                      input logic et, input logic ep, input logic st);
    exp_t e;
    exp_t got;
    logic misp, misp0;
    logic [3:0] ii, ei;
    reset = rs; id_branch = ib; id_jump = ij; id_pc = ipc;
    ex_branch = eb; ex_pc = epc; ex_taken = et; ex_predicted = ep; stall = st;

    ii    = ipc[5:2];
    ei    = epc[5:2];
    misp  = eb & (et != ep);
    misp0 = eb & et;
    e.pt  = ib & ref_tbl[ii][1];
    resolve(rs, misp, et, ij, e.pt, e.fl, e.pcsel);
    e.pt0 = 1'b0;
    resolve(rs, misp0, et, ij, 1'b0, e.fl0, e.pcsel0);
    e.cnt  = ref_stat;
    e.cnt0 = ref_stat0;
    exp_q.push_back(e);

    @(negedge clk);
    got = exp_q.pop_front();
    chk({tag, ".predict_taken"}, 32'(predict_taken), 32'(got.pt));
    chk({tag, ".flush"}, 32'({ifidflush, idexflush, exmemflush}), 32'(got.fl));
    chk({tag, ".pcsel"}, 32'(pcsel), 32'(got.pcsel));
    chk({tag, ".mispredict_count"}, 32'(mispredict_count), 32'(got.cnt));
    chk({tag, ".legacy_predict"}, 32'(predict_taken0), 32'(got.pt0));
    chk({tag, ".legacy_flush"}, 32'({ifidflush0, idexflush0, exmemflush0}), 32'(got.fl0));
    chk({tag, ".legacy_pcsel"}, 32'(pcsel0), 32'(got.pcsel0));
    chk({tag, ".legacy_count"}, 32'(mispredict_count0), 32'(got.cnt0));

    @(posedge clk);
    if (rs) begin
      model_reset();
    end else if (!st) begin
      if (eb) begin
        if (et) ref_tbl[ei] = (ref_tbl[ei] == 2'b11) ? 2'b11 : ref_tbl[ei] + 2'b01;
        else    ref_tbl[ei] = (ref_tbl[ei] == 2'b00) ? 2'b00 : ref_tbl[ei] - 2'b01;
      end
      if (misp && ref_stat != 16'hffff) ref_stat = ref_stat + 16'd1;
      if (misp0 && ref_stat0 != 2'b11) ref_stat0 = ref_stat0 + 2'd1;
    end
    #1;
  endtask

  initial begin
    logic [31:0] pcs [6];
    pcs[0] = 32'h40; pcs[1] = 32'h44; pcs[2] = 32'h48;
    pcs[3] = 32'h80; pcs[4] = 32'h100; pcs[5] = 32'h3c;

    reset = 1'b1; id_branch = 1'b0; id_jump = 1'b0; id_pc = '0;
    ex_branch = 1'b0; ex_pc = '0; ex_taken = 1'b0; ex_predicted = 1'b0; stall = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();

    // Reset holds outputs quiet even with every event requested.
    step("reset_quiet", 1, 1, 1, 32'h40, 1, 32'h40, 1, 0, 0);
    step("post_reset",  0, 1, 0, 32'h40, 0, 32'h0,  0, 0, 0);

    // Two taken mispredicts train 0x40 from 01 to 11.
    step("train_tk1",   0, 0, 0, 32'h0,  1, 32'h40, 1, 0, 0);
    step("train_tk2",   0, 0, 0, 32'h0,  1, 32'h40, 1, 0, 0);
    step("lookup_tk",   0, 1, 0, 32'h40, 0, 32'h0,  0, 0, 0);

    // Saturation at 11, then one not-taken takes it to 10 (still taken).
    for (int i = 0; i < 5; i++)
      step("sat_up",    0, 0, 0, 32'h0,  1, 32'h40, 1, 1, 0);
    step("sat_check",   0, 1, 0, 32'h40, 0, 32'h0,  0, 0, 0);
    step("nt_recover",  0, 0, 0, 32'h0,  1, 32'h40, 0, 1, 0);
    step("still_taken", 0, 1, 0, 32'h40, 0, 32'h0,  0, 0, 0);

    // Mispredict beats a same-cycle jump, both directions.
    step("prio_nt_jmp", 0, 0, 1, 32'h80, 1, 32'h44, 0, 1, 0);
    step("prio_tk_jmp", 0, 1, 1, 32'h40, 1, 32'h48, 1, 0, 0);
    step("jump_only",   0, 0, 1, 32'h80, 0, 32'h0,  0, 0, 0);
    step("correct_nt",  0, 0, 0, 32'h0,  1, 32'h44, 0, 0, 0);

    // Same-index collision: lookup sees the pre-update counter.
    step("collide",     0, 1, 0, 32'h40, 1, 32'h40, 0, 0, 0);
    step("collide_nxt", 0, 1, 0, 32'h40, 0, 32'h0,  0, 0, 0);

    // Stall: flushes assert, counter and stat frozen.
    step("stall_misp",  0, 0, 0, 32'h0,  1, 32'h48, 0, 1, 1);
    step("stall_after", 0, 1, 0, 32'h48, 0, 32'h0,  0, 0, 0);

    // Aliasing: 0x80 shares the 0x40 entry.
    step("alias_tr",    0, 0, 0, 32'h0,  1, 32'h40, 1, 0, 0);
    step("alias_look",  0, 1, 0, 32'h80, 0, 32'h0,  0, 0, 0);

    // Legacy stat saturation: repeated taken branches.
    for (int i = 0; i < 5; i++)
      step("legacy_tk", 0, 1, 0, 32'h40, 1, 32'h40, 1, 1, 0);

    // Mid-operation reset discards the pending update.
    step("mid_reset",   1, 0, 0, 32'h0,  1, 32'h40, 0, 1, 0);
    step("mid_rst_chk", 0, 1, 0, 32'h40, 0, 32'h0,  0, 0, 0);

    // Random mix.
    for (int i = 0; i < 60; i++) begin
      step("rand",
           ($urandom_range(0, 24) == 0),
           1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
           pcs[$urandom_range(0, 5)],
           1'($urandom_range(0, 1)), pcs[$urandom_range(0, 5)],
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 4) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
